// File: rtl/windowed_rf_mmu.sv
// Window spill/fill stack behind the windowed register file's MMU port.
// A spill pushes one window of words streamed on out1. A fill pops the
// most recent window and streams it back on mmu_data. Each completed
// transfer ends with a single-cycle mmu_done pulse.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for a rising spill/fill request
// SPILL      | capturing words 1..WIN_WORDS-1 of a window from out1
// SPILL_DONE | mmu_done high for one cycle, then back to IDLE
// FILL       | presenting words 1..WIN_WORDS-1 of the top window
module windowed_rf_mmu #(
  parameter int DATA_W    = 32,
  parameter int WIN_WORDS = 16,
  parameter int DEPTH_WIN = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           rf_reset,
  input  logic                           spill,
  input  logic                           fill,
  input  logic [DATA_W-1:0]              out1,
  output logic [DATA_W-1:0]              mmu_data,
  output logic                           mmu_done,
  output logic [$clog2(DEPTH_WIN+1)-1:0] win_cnt,
  output logic                           full,
  output logic                           empty,
  output logic                           ovf_err,
  output logic                           unf_err,
  output logic                           proto_err
);

  localparam int CNT_W  = $clog2(DEPTH_WIN + 1);
  localparam int K_W    = $clog2(WIN_WORDS);
  localparam int WORDS  = DEPTH_WIN * WIN_WORDS;
  localparam int ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, SPILL, SPILL_DONE, FILL} state_t;

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [CNT_W-1:0]    win_cnt_q, win_cnt_d;
  logic [DATA_W-1:0]   mmu_data_q, mmu_data_d;
  logic                mmu_done_q, mmu_done_d;
  logic                ovf_err_q, ovf_err_d;
  logic                unf_err_q, unf_err_d;
  logic                proto_err_q, proto_err_d;
  logic                spill_prev_q, fill_prev_q;
  logic [DATA_W-1:0]   mem_q [WORDS];

  logic                spill_edge, fill_edge, last_word;
  logic                mem_we;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;

  assign full  = (win_cnt_q == CNT_W'(DEPTH_WIN));
  assign empty = (win_cnt_q == '0);

  // Next-state, datapath and flag logic; rf_reset overrides everything.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    win_cnt_d   = win_cnt_q;
    mmu_data_d  = mmu_data_q;
    mmu_done_d  = 1'b0;
    ovf_err_d   = ovf_err_q;
    unf_err_d   = unf_err_q;
    proto_err_d = proto_err_q;
    mem_we      = 1'b0;
    spill_edge  = spill & ~spill_prev_q;
    fill_edge   = fill & ~fill_prev_q;
    last_word   = (k_q == K_W'(WIN_WORDS - 1));
    // When full the write address wraps, but mem_we is held low then.
    wr_addr     = ADDR_W'(int'(win_cnt_q) * WIN_WORDS + int'(k_q));
    rd_addr     = ADDR_W'((int'(win_cnt_q) - 1) * WIN_WORDS + int'(k_q));

    unique case (state_q)
      IDLE: begin
        if (spill_edge) begin
          state_d = SPILL;
          k_d     = K_W'(1);
          mem_we  = ~full;
          if (full)      ovf_err_d   = 1'b1;
          if (fill_edge) proto_err_d = 1'b1;
        end else if (fill_edge) begin
          state_d    = FILL;
          k_d        = K_W'(1);
          mmu_data_d = empty ? '0 : mem_q[rd_addr];
          if (empty) unf_err_d = 1'b1;
        end
      end
      SPILL: begin
        if (!spill) begin
          state_d     = IDLE;
          k_d         = '0;
          proto_err_d = 1'b1;
        end else begin
          mem_we = ~full;
          if (last_word) begin
            state_d    = SPILL_DONE;
            k_d        = '0;
            mmu_done_d = 1'b1;
            if (!full) win_cnt_d = win_cnt_q + CNT_W'(1);
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      SPILL_DONE: begin
        state_d = IDLE;
      end
      FILL: begin
        if (!fill) begin
          state_d     = IDLE;
          k_d         = '0;
          proto_err_d = 1'b1;
        end else begin
          mmu_data_d = empty ? '0 : mem_q[rd_addr];
          if (last_word) begin
            state_d    = IDLE;
            k_d        = '0;
            mmu_done_d = 1'b1;
            if (!empty) win_cnt_d = win_cnt_q - CNT_W'(1);
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase

    if (rf_reset) begin
      state_d     = IDLE;
      k_d         = '0;
      win_cnt_d   = '0;
      mmu_data_d  = '0;
      mmu_done_d  = 1'b0;
      ovf_err_d   = 1'b0;
      unf_err_d   = 1'b0;
      proto_err_d = 1'b0;
      mem_we      = 1'b0;
    end
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      k_q          <= '0;
      win_cnt_q    <= '0;
      mmu_data_q   <= '0;
      mmu_done_q   <= 1'b0;
      ovf_err_q    <= 1'b0;
      unf_err_q    <= 1'b0;
      proto_err_q  <= 1'b0;
      spill_prev_q <= 1'b0;
      fill_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      win_cnt_q    <= win_cnt_d;
      mmu_data_q   <= mmu_data_d;
      mmu_done_q   <= mmu_done_d;
      ovf_err_q    <= ovf_err_d;
      unf_err_q    <= unf_err_d;
      proto_err_q  <= proto_err_d;
      spill_prev_q <= spill;
      fill_prev_q  <= fill;
    end
  end

  // Window storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_addr] <= out1;
  end

  assign mmu_data  = mmu_data_q;
  assign mmu_done  = mmu_done_q;
  assign win_cnt   = win_cnt_q;
  assign ovf_err   = ovf_err_q;
  assign unf_err   = unf_err_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_windowed_rf_mmu.sv
// Directed bench for windowed_rf_mmu at default parameters (W=16, depth 4).
module tb_windowed_rf_mmu;

  logic        clk;
  logic        reset;
  logic        rf_reset;
  logic        spill;
  logic        fill;
  logic [31:0] out1;
  logic [31:0] mmu_data;
  logic        mmu_done;
  logic [2:0]  win_cnt;
  logic        full;
  logic        empty;
  logic        ovf_err;
  logic        unf_err;
  logic        proto_err;

  int n_cmp;
  int n_err;
  int pulses;

  windowed_rf_mmu #(.DATA_W(32), .WIN_WORDS(16), .DEPTH_WIN(4)) dut (
    .clk(clk), .reset(reset), .rf_reset(rf_reset), .spill(spill), .fill(fill),
    .out1(out1), .mmu_data(mmu_data), .mmu_done(mmu_done), .win_cnt(win_cnt),
    .full(full), .empty(empty), .ovf_err(ovf_err), .unf_err(unf_err),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [2:0] exp_cnt,
                             input logic ovf, input logic unf, input logic proto);
    check({tag, "_win_cnt"}, 32'(win_cnt), 32'(exp_cnt));
    check({tag, "_full"},    32'(full),    32'(exp_cnt == 3'd4));
    check({tag, "_empty"},   32'(empty),   32'(exp_cnt == 3'd0));
    check({tag, "_ovf"},     32'(ovf_err), 32'(ovf));
    check({tag, "_unf"},     32'(unf_err), 32'(unf));
    check({tag, "_proto"},   32'(proto_err), 32'(proto));
  endtask

  // Full 16-word spill of base+0..base+15; checks done timing and new count.
  task automatic do_spill(input logic [31:0] base, input logic [2:0] exp_cnt);
    spill = 1'b1;
    for (int k = 0; k < 16; k++) begin
      out1 = base + 32'(k);
      tick();
      if (k < 15) check("spill_done_early", 32'(mmu_done), 32'd0);
    end
    check("spill_done", 32'(mmu_done), 32'd1);
    check("spill_cnt", 32'(win_cnt), 32'(exp_cnt));
    spill = 1'b0;
    tick();
    check("spill_done_clear", 32'(mmu_done), 32'd0);
  endtask

  // Full 16-word fill; expects base+k per word, or zeros when is_zero.
  task automatic do_fill(input logic [31:0] base, input logic [2:0] exp_cnt, input logic is_zero);
    fill = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("fill_data", mmu_data, is_zero ? 32'd0 : base + 32'(k));
      check("fill_done", 32'(mmu_done), 32'(k == 15));
    end
    check("fill_cnt", 32'(win_cnt), 32'(exp_cnt));
    fill = 1'b0;
    tick();
    check("fill_done_clear", 32'(mmu_done), 32'd0);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b0;
    rf_reset = 1'b0;
    spill    = 1'b0;
    fill     = 1'b0;
    out1     = '0;
    #1;
    check("rst_data", mmu_data, 32'd0);
    check("rst_done", 32'(mmu_done), 32'd0);
    check_flags("rst", 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Single window round trip
    do_spill(32'hA0, 3'd1);
    do_fill(32'hA0, 3'd0, 1'b0);

    // Fill the stack, overflow once, drain in LIFO order
    do_spill(32'h10, 3'd1);
    do_spill(32'h20, 3'd2);
    do_spill(32'h30, 3'd3);
    do_spill(32'h40, 3'd4);
    check_flags("full", 3'd4, 1'b0, 1'b0, 1'b0);
    do_spill(32'h50, 3'd4);
    check_flags("ovf", 3'd4, 1'b1, 1'b0, 1'b0);
    do_fill(32'h40, 3'd3, 1'b0);
    do_fill(32'h30, 3'd2, 1'b0);
    do_fill(32'h20, 3'd1, 1'b0);
    do_fill(32'h10, 3'd0, 1'b0);

    // Underflow: zeros, done still pulses
    do_fill(32'h0, 3'd0, 1'b1);
    check_flags("unf", 3'd0, 1'b1, 1'b1, 1'b0);

    // rf_reset clears sticky flags
    rf_reset = 1'b1;
    tick();
    rf_reset = 1'b0;
    check_flags("rfrst_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // Short spill of 7 words
    spill = 1'b1;
    for (int k = 0; k < 7; k++) begin
      out1 = 32'hE0 + 32'(k);
      tick();
      check("short_done", 32'(mmu_done), 32'd0);
    end
    spill = 1'b0;
    tick();
    check("short_done_end", 32'(mmu_done), 32'd0);
    check_flags("short", 3'd0, 1'b0, 1'b0, 1'b1);
    do_spill(32'h60, 3'd1);
    do_fill(32'h60, 3'd0, 1'b0);

    // Spill held for 40 cycles: one transfer only
    pulses = 0;
    spill  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      out1 = 32'h70 + 32'(i);
      tick();
      if (mmu_done) pulses++;
    end
    spill = 1'b0;
    tick();
    check("held_pulses", 32'(pulses), 32'd1);
    check("held_cnt", 32'(win_cnt), 32'd1);
    do_fill(32'h70, 3'd0, 1'b0);

    // rf_reset at word 8 of a fill
    do_spill(32'h90, 3'd1);
    do_spill(32'hB0, 3'd2);
    fill = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("abort_fill_data", mmu_data, 32'hB0 + 32'(k));
    end
    rf_reset = 1'b1;
    tick();
    rf_reset = 1'b0;
    fill     = 1'b0;
    check("abort_data", mmu_data, 32'd0);
    check("abort_done", 32'(mmu_done), 32'd0);
    check_flags("abort", 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("abort_done_after", 32'(mmu_done), 32'd0);
    do_spill(32'hC0, 3'd1);

    // Asynchronous reset mid-spill
    spill = 1'b1;
    for (int k = 0; k < 5; k++) begin
      out1 = 32'hF0 + 32'(k);
      tick();
    end
    #3 reset = 1'b0;
    #1;
    check("arst_done", 32'(mmu_done), 32'd0);
    check("arst_data", mmu_data, 32'd0);
    check_flags("arst", 3'd0, 1'b0, 1'b0, 1'b0);
    spill = 1'b0;
    #1 reset = 1'b1;
    tick();
    check("arst_idle_cnt", 32'(win_cnt), 32'd0);
    do_spill(32'hD0, 3'd1);
    do_fill(32'hD0, 3'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
